regbank_wr_arbiter: RTL and testbench

Shares the single write port of the 32 x 32-bit register bank among NREQ writeback requesters with round-robin fairness. It also runs a bank-clear sweep that zeroes all 32 registers through the normal write port. The block sits between the writeback sources and the register bank's write/dr/wrData inputs, and is the only driver of those inputs.

---
 rtl/regbank_pkg.sv | 17 +
 rtl/rr_picker.sv | 30 +++
 rtl/regbank_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_regbank_wr_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and state type for the register-bank write arbiter.
package regbank_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic {
        ARB = 1'b0,
        CLR = 1'b1
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first asserted request scanning upward from ptr, wrapping modulo NREQ.
module rr_picker #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PTR_W'((32'(ptr) + i) % NREQ);
            if (!grant_vld && req[cand]) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin owner of the register bank write port, plus a 32-entry clear sweep.
// Optional REGBANK_R0_ZERO_EN: writes to register 0 are acked but suppressed.
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*5-1:0]      req_dr,
    input  logic [NREQ*32-1:0]     req_data,
    output logic [NREQ-1:0]        ack,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   write,
    output logic [4:0]             dr,
    output logic [31:0]            wrData
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [REG_ADDR_W-1:0]   idx_q, idx_d;
    logic                    write_q, write_d;
    logic [REG_ADDR_W-1:0]   dr_q, dr_d;
    logic [DATA_W-1:0]       wrdata_q, wrdata_d;
    logic                    clr_busy_q, clr_busy_d;
    logic                    clr_done_q, clr_done_d;
    logic [NREQ-1:0]         ack_c;

    logic [NREQ-1:0]         grant;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant_vld;
    logic [REG_ADDR_W-1:0]   sel_dr;
    logic [DATA_W-1:0]       sel_data;

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign sel_dr   = req_dr[32'(grant_idx) * REG_ADDR_W +: REG_ADDR_W];
    assign sel_data = req_data[32'(grant_idx) * DATA_W +: DATA_W];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        write_d    = 1'b0;
        dr_d       = dr_q;
        wrdata_d   = wrdata_q;
        clr_busy_d = clr_busy_q;
        clr_done_d = 1'b0;
        ack_c      = '0;
        case (state_q)
            ARB: begin
                if (clr_req) begin
                    state_d    = CLR;
                    idx_d      = '0;
                    clr_busy_d = 1'b1;
                end else if (grant_vld) begin
                    ack_c = grant;
                    ptr_d = PTR_W'(wrap_inc(32'(grant_idx), NREQ));
`ifdef REGBANK_R0_ZERO_EN
                    if (sel_dr != '0) begin
                        write_d  = 1'b1;
                        dr_d     = sel_dr;
                        wrdata_d = sel_data;
                    end
`else
                    write_d  = 1'b1;
                    dr_d     = sel_dr;
                    wrdata_d = sel_data;
`endif
                end
            end
            CLR: begin
                write_d  = 1'b1;
                dr_d     = idx_q;
                wrdata_d = '0;
                if (idx_q == REG_ADDR_W'(NUM_REGS - 1)) begin
                    state_d    = ARB;
                    clr_busy_d = 1'b0;
                    clr_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            dr_q       <= '0;
            wrdata_q   <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            dr_q       <= dr_d;
            wrdata_q   <= wrdata_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    // ack is combinational; masking with reset_n keeps it at its reset value while reset is held
    assign ack      = ack_c & {NREQ{reset_n}};
    assign write    = write_q;
    assign dr       = dr_q;
    assign wrData   = wrdata_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Self-checking bench for regbank_wr_arbiter (NREQ=4): directed steps plus random traffic vs a reference model.
module tb_regbank_wr_arbiter;

    localparam int NREQ = 4;
`ifdef REGBANK_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic               clk;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*5-1:0]  req_dr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               clr_req;
    logic               clr_busy;
    logic               clr_done;
    logic               write;
    logic [4:0]         dr;
    logic [31:0]        wrData;

    regbank_wr_arbiter #(.NREQ(NREQ)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_dr   (req_dr),
        .req_data (req_data),
        .ack      (ack),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .write    (write),
        .dr       (dr),
        .wrData   (wrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // requester-side view
    bit          pend  [NREQ];
    logic [4:0]  pdr   [NREQ];
    logic [31:0] pdata [NREQ];

    // reference model
    int          m_ptr;
    bit          m_sweep;
    int          m_idx;
    logic        m_write;
    logic [4:0]  m_dr;
    logic [31:0] m_data;
    logic        m_busy;
    logic        m_done;

    logic [NREQ-1:0] last_ack;
    logic [NREQ-1:0] obs_ack;
    int              n_done;
    int              n_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]               = pend[i];
            req_dr[5*i +: 5]     = pdr[i];
            req_data[32*i +: 32] = pdata[i];
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_sweep = 1'b0;
        m_idx   = 0;
        m_write = 1'b0;
        m_dr    = '0;
        m_data  = '0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic new_payload(input int i);
        pdr[i]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        pdata[i] = $urandom;
    endtask

    // One clock cycle: check ack mid-cycle, advance model at the edge, check registered outputs.
    task automatic step();
        int g;
        logic [NREQ-1:0] ea;
        #2;
        g  = -1;
        ea = '0;
        if (!m_sweep && !clr_req) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        if (g >= 0) ea[g[1:0]] = 1'b1;
        obs_ack = ack;
        chk("ack", 32'(ack), 32'(ea));
        @(posedge clk);
        m_done = 1'b0;
        if (m_sweep) begin
            m_write = 1'b1;
            m_dr    = 5'(m_idx);
            m_data  = '0;
            if (m_idx == 31) begin
                m_sweep = 1'b0;
                m_busy  = 1'b0;
                m_done  = 1'b1;
            end else begin
                m_idx++;
            end
        end else if (clr_req) begin
            m_sweep = 1'b1;
            m_idx   = 0;
            m_busy  = 1'b1;
            m_write = 1'b0;
        end else if (g >= 0) begin
            m_ptr   = (g + 1) % NREQ;
            m_write = !(R0Z && pdr[g] == 5'd0);
            if (m_write) begin
                m_dr   = pdr[g];
                m_data = pdata[g];
            end
        end else begin
            m_write = 1'b0;
        end
        #1;
        chk("write",    32'(write),    32'(m_write));
        chk("dr",       32'(dr),       32'(m_dr));
        chk("wrData",   wrData,        m_data);
        chk("clr_busy", 32'(clr_busy), 32'(m_busy));
        chk("clr_done", 32'(clr_done), 32'(m_done));
        if (clr_done === 1'b1) n_done++;
        if (clr_busy === 1'b1) n_busy++;
        last_ack = ea;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] rr_tbl [5];
        rr_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        reset_n = 1'b0;
        clr_req = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b1;
            pdr[i]   = 5'(i + 3);
            pdata[i] = 32'hA000_0000 + 32'(i);
        end
        drive();
        model_reset();
        last_ack = '0;
        n_done = 0;
        n_busy = 0;

        // reset values, with requests present
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write",    32'(write),    0);
        chk("rst_dr",       32'(dr),       0);
        chk("rst_wrData",   wrData,        0);
        chk("rst_ack",      32'(ack),      0);
        chk("rst_clr_busy", 32'(clr_busy), 0);
        chk("rst_clr_done", 32'(clr_done), 0);
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
        reset_n = 1'b1;

        // single requester on slot 2
        pend[2] = 1'b1; pdr[2] = 5'd7; pdata[2] = 32'hDEAD_BEEF;
        drive();
        step();
        chk("single_ack",    32'(obs_ack), 32'h4);
        chk("single_write",  32'(write),   1);
        chk("single_dr",     32'(dr),      7);
        chk("single_wrData", wrData,       32'hDEAD_BEEF);
        pend[2] = 1'b0;
        drive();
        step();
        // ptr now 3: all requesting picks slot 3 first
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
        drive();
        step();
        chk("ptr_after_single", 32'(obs_ack), 32'h8);

        // all four from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b1;
            pdr[i]   = 5'(10 + i);
            pdata[i] = 32'h1111_1111 * 32'(i + 1);
        end
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq", 32'(obs_ack), 32'(rr_tbl[k]));
        end

        // clear sweep with req=0011 held, plus a stray clr_req at idx=5
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = (i < 2);
        drive();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n_done = 0;
        n_busy = 1;
        for (int k = 0; k < 34; k++) begin
            clr_req = (k == 5);
            step();
        end
        clr_req = 1'b0;
        chk("sweep_done_count", 32'(n_done), 1);
        chk("sweep_busy_cycles", 32'(n_busy), 32);

        // reset while idx=10
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
        drive();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (10) step();
        n_done = 0;
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_write",    32'(write),    0);
        chk("midrst_dr",       32'(dr),       0);
        chk("midrst_wrData",   wrData,        0);
        chk("midrst_ack",      32'(ack),      0);
        chk("midrst_clr_busy", 32'(clr_busy), 0);
        chk("midrst_clr_done", 32'(clr_done), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) step();
        chk("midrst_no_done", 32'(n_done), 0);

        // write to register 0
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        pend[0] = 1'b1; pdr[0] = 5'd0; pdata[0] = 32'h1234_5678;
        drive();
        step();
        chk("r0_ack",   32'(obs_ack), 32'h1);
        chk("r0_write", 32'(write),   R0Z ? 0 : 1);
        pend[0] = 1'b0;
        drive();
        step();

        // random traffic
        do_reset();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        last_ack = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_ack[i]) begin
                    pend[i] = 1'($urandom_range(0, 1));
                    new_payload(i);
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    new_payload(i);
                end
            end
            clr_req = ($urandom_range(0, 49) == 0);
            drive();
            step();
        end
        clr_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
